// File: rtl/rft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rft_pkg: command codes, reply bytes and FSM state type for the     |
// | UART-driven CUT loopback controller.          Revision: 1.0        |
// +--------------------------------------------------------------------+
package rft_pkg;

    localparam logic [7:0] c_CMD_LOAD_PT  = 8'h01;
    localparam logic [7:0] c_CMD_LOAD_KEY = 8'h02;
    localparam logic [7:0] c_CMD_RUN      = 8'h03;
    localparam logic [7:0] c_CMD_READ_CT  = 8'h04;

    localparam logic [7:0] c_ACK = 8'hA5;
    localparam logic [7:0] c_ERR = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN_RST = 3'd2,
        ST_RUN     = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_SEND    = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rft_cut_clk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rft_cut_clk_gen: divides clk into cut_clk and emits exactly        |
// | RUN_CYCLES rising edges per start pulse.      Revision: 1.0        |
// +--------------------------------------------------------------------+
module rft_cut_clk_gen #(
    parameter int RUN_CYCLES = 16,
    parameter int HALF_DIV   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic cut_clk,
    output logic cut_clk_rise,
    output logic done
);

    localparam int c_EDGE_W = $clog2(RUN_CYCLES + 1);
    localparam int c_DIV_W  = $clog2(HALF_DIV + 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(RUN_CYCLES);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(HALF_DIV - 1);

    if (RUN_CYCLES < 1 || HALF_DIV < 1) begin : g_bad_params
        $error("rft_cut_clk_gen: RUN_CYCLES and HALF_DIV must both be at least 1");
    end

    logic                r_active;
    logic                r_clk;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_EDGE_W-1:0] r_edges;
    logic                w_half_end;

    assign w_half_end   = r_active && (r_div == c_DIV_LAST);
    // Both strobes are decoded one cycle ahead so the consumer's register
    // lands on the same clk edge that moves cut_clk.
    assign cut_clk_rise = w_half_end && !r_clk;
    assign done         = w_half_end && r_clk && (r_edges == c_EDGE_LAST);
    assign cut_clk      = r_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_clk    <= 1'b0;
            r_div    <= '0;
            r_edges  <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_clk    <= 1'b0;
            r_div    <= '0;
            r_edges  <= '0;
        end else if (w_half_end) begin
            r_div <= '0;
            if (!r_clk) begin
                r_clk   <= 1'b1;
                r_edges <= r_edges + c_EDGE_W'(1);
            end else begin
                r_clk <= 1'b0;
                if (r_edges == c_EDGE_LAST) begin
                    r_active <= 1'b0;
                end
            end
        end else if (r_active) begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rft_loopback_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rft_loopback_ctrl: UART command FSM that loads, clocks and reads   |
// | back a cipher core under test.                Revision: 1.0        |
// +--------------------------------------------------------------------+
module rft_loopback_ctrl
    import rft_pkg::*;
#(
    parameter int PT_W       = 64,
    parameter int KEY_W      = 128,
    parameter int CT_W       = 64,
    parameter int RUN_CYCLES = 16,
    parameter int HALF_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              cut_clk,
    output logic              cut_rst_n,
    output logic [PT_W-1:0]   cut_plaintext,
    output logic [KEY_W-1:0]  cut_key,
    input  logic [CT_W-1:0]   cut_ciphertext
);

    localparam int c_PT_BYTES  = PT_W / 8;
    localparam int c_KEY_BYTES = KEY_W / 8;
    localparam int c_CT_BYTES  = CT_W / 8;
    localparam int c_CNT_W     = $clog2(max3(c_PT_BYTES, c_KEY_BYTES, c_CT_BYTES) + 1);
    localparam int c_STAGE_W   = (PT_W > KEY_W) ? PT_W : KEY_W;
    localparam int c_RST_CLKS  = 4 * HALF_DIV;
    localparam int c_RST_W     = $clog2(c_RST_CLKS + 1);

    localparam logic [c_CNT_W-1:0] c_PT_LAST  = c_CNT_W'(c_PT_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_KEY_LAST = c_CNT_W'(c_KEY_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_CT_CNT   = c_CNT_W'(c_CT_BYTES);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(c_RST_CLKS - 1);
    localparam logic [CT_W-1:0]    c_ACK_BUF  = CT_W'(c_ACK) << (CT_W - 8);
    localparam logic [CT_W-1:0]    c_ERR_BUF  = CT_W'(c_ERR) << (CT_W - 8);

    if (PT_W < 8 || (PT_W % 8) != 0 || KEY_W < 8 || (KEY_W % 8) != 0 ||
        CT_W < 8 || (CT_W % 8) != 0) begin : g_bad_width
        $error("rft_loopback_ctrl: PT_W, KEY_W and CT_W must be nonzero multiples of 8");
    end

    state_t               r_state;
    logic                 r_is_key;
    logic [c_STAGE_W-1:0] r_stage;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   r_total;
    logic [CT_W-1:0]      r_txbuf;
    logic                 r_wait_fall;
    logic [c_RST_W-1:0]   r_rst_cnt;
    logic [CT_W-1:0]      r_ct;

    logic [c_STAGE_W+7:0] w_stage_ext;
    logic [c_STAGE_W-1:0] w_stage_next;
    logic                 w_load_last;
    logic                 w_gen_start;
    logic                 w_gen_done;
    logic                 w_rise_unused;

    assign w_stage_ext  = {r_stage, rx_data};
    assign w_stage_next = w_stage_ext[c_STAGE_W-1:0];
    assign w_load_last  = (r_cnt == (r_is_key ? c_KEY_LAST : c_PT_LAST));
    assign w_gen_start  = (r_state == ST_RUN_RST) && (r_rst_cnt == c_RST_LAST);

    rft_cut_clk_gen #(
        .RUN_CYCLES (RUN_CYCLES),
        .HALF_DIV   (HALF_DIV)
    ) u_clk_gen (
        .clk          (clk),
        .rst          (rst),
        .start        (w_gen_start),
        .cut_clk      (cut_clk),
        .cut_clk_rise (w_rise_unused),
        .done         (w_gen_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_is_key      <= 1'b0;
            r_stage       <= '0;
            r_cnt         <= '0;
            r_total       <= '0;
            r_txbuf       <= '0;
            r_wait_fall   <= 1'b0;
            r_rst_cnt     <= '0;
            r_ct          <= '0;
            tx_start      <= 1'b0;
            tx_data       <= 8'h00;
            cut_rst_n     <= 1'b0;
            cut_plaintext <= '0;
            cut_key       <= '0;
        end else begin
            tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_ready) begin
                        r_cnt       <= '0;
                        r_wait_fall <= 1'b0;
                        case (rx_data)
                            c_CMD_LOAD_PT: begin
                                r_is_key <= 1'b0;
                                r_state  <= ST_LOAD;
                            end
                            c_CMD_LOAD_KEY: begin
                                r_is_key <= 1'b1;
                                r_state  <= ST_LOAD;
                            end
                            c_CMD_RUN: begin
                                cut_rst_n <= 1'b0;
                                r_rst_cnt <= '0;
                                r_state   <= ST_RUN_RST;
                            end
                            c_CMD_READ_CT: begin
                                r_txbuf <= r_ct;
                                r_total <= c_CT_CNT;
                                r_state <= ST_SEND;
                            end
                            default: begin
                                r_txbuf <= c_ERR_BUF;
                                r_total <= c_ONE;
                                r_state <= ST_SEND;
                            end
                        endcase
                    end
                end

                ST_LOAD: begin
                    if (rx_ready) begin
                        r_stage <= w_stage_next;
                        r_cnt   <= r_cnt + c_ONE;
                        if (w_load_last) begin
                            // Target only changes here, so a partial load is invisible.
                            if (r_is_key) begin
                                cut_key <= w_stage_next[KEY_W-1:0];
                            end else begin
                                cut_plaintext <= w_stage_next[PT_W-1:0];
                            end
                            r_txbuf     <= c_ACK_BUF;
                            r_total     <= c_ONE;
                            r_cnt       <= '0;
                            r_wait_fall <= 1'b0;
                            r_state     <= ST_SEND;
                        end
                    end
                end

                ST_RUN_RST: begin
                    if (w_gen_start) begin
                        cut_rst_n <= 1'b1;
                        r_state   <= ST_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + c_RST_W'(1);
                    end
                end

                ST_RUN: begin
                    if (w_gen_done) begin
                        r_ct    <= cut_ciphertext;
                        r_state <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    r_txbuf     <= c_ACK_BUF;
                    r_total     <= c_ONE;
                    r_cnt       <= '0;
                    r_wait_fall <= 1'b0;
                    r_state     <= ST_SEND;
                end

                ST_SEND: begin
                    // Each byte needs the transmitter to go busy and come back
                    // idle before the next one, including after the last byte.
                    if (r_wait_fall) begin
                        if (!tx_ready) begin
                            r_wait_fall <= 1'b0;
                            if (r_cnt == r_total) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else if (tx_ready && (r_cnt != r_total)) begin
                        tx_start    <= 1'b1;
                        tx_data     <= r_txbuf[CT_W-1 -: 8];
                        r_txbuf     <= r_txbuf << 8;
                        r_cnt       <= r_cnt + c_ONE;
                        r_wait_fall <= 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rft_loopback_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rft_loopback_ctrl: directed bench with a byte scoreboard, UART  |
// | transmitter model and an edge-counting CUT stub. Revision: 1.0     |
// +--------------------------------------------------------------------+
module tb_rft_loopback_ctrl;
    import rft_pkg::*;

    localparam int PT_W       = 64;
    localparam int KEY_W      = 128;
    localparam int CT_W       = 64;
    localparam int RUN_CYCLES = 16;
    localparam int HALF_DIV   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_ready = 1'b1;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              cut_clk;
    logic              cut_rst_n;
    logic [PT_W-1:0]   cut_plaintext;
    logic [KEY_W-1:0]  cut_key;
    logic [CT_W-1:0]   cut_ciphertext;

    int errors = 0;
    int checks = 0;
    int tx_count = 0;
    int exp_total = 0;
    int busy = 0;
    logic [7:0] exp_q[$];

    logic [CT_W-1:0] stub_ct;
    logic            stub_mix;
    int              stub_edges = 0;
    int              raw_edges = 0;

    always #5 clk = ~clk;

    rft_loopback_ctrl #(
        .PT_W(PT_W), .KEY_W(KEY_W), .CT_W(CT_W),
        .RUN_CYCLES(RUN_CYCLES), .HALF_DIV(HALF_DIV)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .cut_clk(cut_clk), .cut_rst_n(cut_rst_n),
        .cut_plaintext(cut_plaintext), .cut_key(cut_key),
        .cut_ciphertext(cut_ciphertext)
    );

    // CUT stub: edge counter cleared by its reset; optional edge-dependent result
    always @(posedge cut_clk or negedge cut_rst_n) begin
        if (!cut_rst_n) stub_edges <= 0;
        else            stub_edges <= stub_edges + 1;
    end
    always @(posedge cut_clk) raw_edges <= raw_edges + 1;
    assign cut_ciphertext = stub_mix ? (stub_ct ^ CT_W'(stub_edges)) : stub_ct;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        exp_total++;
    endtask

    // UART transmitter model and scoreboard consumer
    always @(negedge clk) begin
        if (rst) begin
            tx_ready = 1'b1;
            busy = 0;
        end else if (tx_start) begin
            tx_count++;
            chk("tx_ready_at_start", tx_ready, 1);
            chk("tx_byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
            tx_ready = 1'b0;
            busy = 4;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) tx_ready = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && tx_ready && dut.r_state == ST_IDLE) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_reply_done"}, ok, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_cut_clk"}, cut_clk, 0);
        chk({tag, "_cut_rst_n"}, cut_rst_n, 0);
        chk({tag, "_plaintext"}, cut_plaintext, 0);
        chk({tag, "_key"}, cut_key, 0);
        chk({tag, "_captured_ct"}, dut.r_ct, 0);
        chk({tag, "_state"}, dut.r_state, ST_IDLE);
    endtask

    task automatic do_run(input string tag);
        int low;
        int raw0;
        bit quiet;
        quiet = 1'b1;
        raw0 = raw_edges;
        expect_byte(c_ACK);
        @(negedge clk);
        rx_data = c_CMD_RUN;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        low = 0;
        while (cut_rst_n === 1'b0 && low < 1000) begin
            if (cut_clk !== 1'b0) quiet = 1'b0;
            low++;
            @(negedge clk);
        end
        chk({tag, "_rst_low_clks"}, low, 4 * HALF_DIV);
        chk({tag, "_clk_low_in_rst"}, quiet, 1);
        // stray bytes while the CUT is being clocked must be ignored
        send_byte(c_CMD_LOAD_PT);
        send_byte(8'h7F);
        wait_idle(tag);
        chk({tag, "_stub_edges"}, stub_edges, RUN_CYCLES);
        chk({tag, "_total_edges"}, raw_edges - raw0, RUN_CYCLES);
        chk({tag, "_cut_clk_idle"}, cut_clk, 0);
        chk({tag, "_cut_rst_n_high"}, cut_rst_n, 1);
    endtask

    task automatic read_ct(input string tag, input logic [CT_W-1:0] exp_ct);
        logic [CT_W-1:0] v;
        v = exp_ct;
        for (int i = 0; i < CT_W / 8; i++) begin
            expect_byte(v[CT_W-1 -: 8]);
            v = v << 8;
        end
        send_byte(c_CMD_READ_CT);
        send_byte(c_CMD_LOAD_KEY);
        wait_idle(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [KEY_W-1:0] key_exp;
        rst = 1'b1;
        rx_data = 8'h00;
        rx_ready = 1'b0;
        stub_ct = 64'hDEADBEEFCAFEF00D;
        stub_mix = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        expect_byte(c_ACK);
        send_byte(c_CMD_LOAD_PT);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
            if (i == 7) chk("pt_partial_unchanged", cut_plaintext, 0);
        end
        wait_idle("load_pt");
        chk("plaintext", cut_plaintext, 64'h0102030405060708);
        chk("cut_rst_n_before_run", cut_rst_n, 0);

        expect_byte(c_ACK);
        send_byte(c_CMD_LOAD_KEY);
        key_exp = '0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h10 + 8'(i));
            key_exp = {key_exp[KEY_W-9:0], 8'h10 + 8'(i)};
        end
        wait_idle("load_key");
        chk("key", cut_key, key_exp);
        chk("key_value", cut_key, 128'h101112131415161718191A1B1C1D1E1F);

        do_run("run1");
        read_ct("read_ct1", 64'hDEADBEEFCAFEF00D);

        stub_ct = 64'h0123456789ABCDE0;
        stub_mix = 1'b1;
        do_run("run2");
        read_ct("read_ct2", 64'h0123456789ABCDE0 ^ 64'(RUN_CYCLES));
        stub_mix = 1'b0;

        expect_byte(c_ERR);
        send_byte(8'h7F);
        wait_idle("bad_cmd");
        chk("bad_cmd_state", dut.r_state, ST_IDLE);
        expect_byte(c_ACK);
        send_byte(c_CMD_LOAD_PT);
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
        wait_idle("load_pt_after_err");
        chk("plaintext_after_err", cut_plaintext, 64'h1112131415161718);

        send_byte(c_CMD_LOAD_PT);
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("cut_rst_n_after_rst", cut_rst_n, 0);
        expect_byte(c_ACK);
        send_byte(c_CMD_LOAD_PT);
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
        wait_idle("load_pt_after_rst");
        chk("plaintext_after_rst", cut_plaintext, 64'hA0A1A2A3A4A5A6A7);
        chk("key_after_rst", cut_key, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("tx_byte_count", tx_count, exp_total);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rft_loopback_ctrl.md
RFT_LOOPBACK_CTRL -- requirements
Module: rft_loopback_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): PT_W, 64, CUT plaintext width in bits.
REQ-002 KEY_W, 128, CUT key width in bits.
REQ-003 CT_W, 64, CUT ciphertext width in bits.
REQ-004 RUN_CYCLES, 16, cut_clk rising edges per run, minimum 1.
REQ-005 HALF_DIV, 2, clk cycles per cut_clk half-period, minimum 1.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-007 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_data  in  8  received UART byte.
- rx_ready  in  1  one-cycle pulse; rx_data valid.
- tx_ready  in  1  UART transmitter idle.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  8  byte to transmit.
- cut_clk  out  1  generated CUT clock.
- cut_rst_n  out  1  CUT active-low reset.
- cut_plaintext  out  PT_W  CUT plaintext input.
- cut_key  out  KEY_W  CUT key input.
- cut_ciphertext  in  CT_W  CUT result.

Function
REQ-008 PT_W, KEY_W and CT_W SHALL each be a nonzero multiple of 8; violation SHALL be an elaboration-time error.
REQ-009 Commands SHALL be one byte each: 0x01 LOAD_PT, 0x02 LOAD_KEY, 0x03 RUN, 0x04 READ_CT.
REQ-010 LOAD_PT/LOAD_KEY SHALL accept the next PT_W/8 or KEY_W/8 bytes, MSB byte first, shifting them into a staging register.
REQ-011 The target output SHALL update atomically on the last byte of a load; partial loads SHALL leave it unchanged.
REQ-012 A completed load SHALL be answered with one ACK byte, 0xA5.
REQ-013 RUN SHALL drive cut_rst_n low for 2 full cut_clk periods, then high.
REQ-014 RUN SHALL then produce exactly RUN_CYCLES cut_clk rising edges.
REQ-015 cut_ciphertext SHALL be captured HALF_DIV clk cycles after the last rising edge, followed by ACK 0xA5.
REQ-016 cut_clk SHALL be held low whenever no RUN is active.
REQ-017 READ_CT SHALL transmit the captured ciphertext as CT_W/8 bytes, MSB byte first.
REQ-018 Any other command byte SHALL be answered with 0xEE, and the block SHALL return to IDLE.
REQ-019 The states SHALL be IDLE, LOAD, RUN_RST, RUN, CAPTURE, SEND, with these transitions:
- IDLE to LOAD, RUN_RST or SEND on command.
- LOAD to SEND (ACK) on the last byte.
- RUN_RST to RUN to CAPTURE to SEND (ACK).
- SEND to IDLE after the last byte.
REQ-020 tx_start SHALL pulse for exactly one cycle, only while tx_ready=1, with tx_data stable from that cycle until the next pulse.
REQ-021 Consecutive bytes SHALL wait for tx_ready to fall and then rise again.
REQ-022 rx_ready pulses arriving in RUN_RST, RUN, CAPTURE or SEND SHALL be discarded without side effects.
REQ-023 Byte counters SHALL be sized $clog2(max(bytes)+1) and SHALL NOT wrap within a transfer.
REQ-024 The cut_clk edge counter SHALL stop at RUN_CYCLES; there SHALL be no extra edge.

Reset
REQ-025 On rst the block SHALL drive: tx_start=0, tx_data=0x00, cut_clk=0, cut_rst_n=0, cut_plaintext=0, cut_key=0; captured ciphertext=0; state=IDLE; all counters 0.
REQ-026 rst asserted mid-operation SHALL abort immediately with the REQ-025 values, and no partial byte SHALL be sent.
REQ-027 After rst, cut_rst_n SHALL stay 0 until the first RUN releases it.

Structure
REQ-028 Package rft_pkg SHALL hold the command codes, ACK (0xA5), ERR (0xEE) and the state enum type.
REQ-029 The divider and edge counter SHALL be one sub-module, rft_cut_clk_gen, with inputs start and params and outputs cut_clk, rising-edge strobe and done.
REQ-030 The protocol FSM and shift registers SHALL reside in rft_loopback_ctrl.

Verification
REQ-031 Send LOAD_PT plus 8 bytes 0x01..0x08 -> cut_plaintext=0x0102030405060708, then one 0xA5.
REQ-032 Send LOAD_KEY plus 16 bytes; send RUN with a CUT stub counting edges -> stub count=RUN_CYCLES, cut_rst_n low for exactly 2*2*HALF_DIV clks, then 0xA5.
REQ-033 With the CUT stub returning 0xDEADBEEFCAFEF00D, send READ_CT -> bytes DE AD BE EF CA FE F0 0D in order, one tx_start per tx_ready cycle.
REQ-034 Send command 0x7F -> one 0xEE byte, state IDLE; a following LOAD_PT works normally.
REQ-035 Send LOAD_PT plus 3 bytes, then assert rst -> all outputs at reset values, cut_plaintext=0; then a full LOAD_PT succeeds.
REQ-036 Inject rx_ready pulses during RUN and SEND -> no output change; transmitted bytes match REQ-032 and REQ-033 exactly.
